exec_sequencer: RTL and testbench

Multi-cycle operation controller for the execute stage. It sits between decode/issue and `execute` and owns the `latancy` count that `execute` samples for FPU add/sub/mul, sqrt and integer divide. It stalls the front end while a multi-cycle op or an `IN` waiting on the UART receive buffer is in flight. It also generates the single-cycle `is_in` consume pulse and a saturating stall-cycle performance counter.

---
 rtl/exec_pkg.sv | 27 ++
 rtl/exec_lat_decode.sv | 39 +++
 rtl/exec_sequencer.sv | 125 ++++++++++++
 tb/tb_exec_sequencer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/exec_pkg.sv
// Shared execute-stage encodings: op classes, opcode/funct/FPU codes and
// the multi-cycle sequencer state type.
package exec_pkg;

  localparam logic [1:0] OPT_IJ  = 2'b00;
  localparam logic [1:0] OPT_R   = 2'b01;
  localparam logic [1:0] OPT_FPU = 2'b10;

  localparam logic [5:0] OP_IN    = 6'b111110;
  localparam logic [5:0] FUNC_DIV = 6'b011010;
  localparam logic [5:0] FPU_ADD  = 6'b000000;
  localparam logic [5:0] FPU_SUB  = 6'b000001;
  localparam logic [5:0] FPU_MUL  = 6'b000010;
  localparam logic [5:0] FPU_SQRT = 6'b000100;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MULTI   = 2'd1,
    WAIT_IN = 2'd2
  } seq_state_t;

  // True for the FPU functions that share the add/sub/mul pipeline latency.
  function automatic logic is_fadd_class(input logic [5:0] fn);
    return (fn == FPU_ADD) || (fn == FPU_SUB) || (fn == FPU_MUL);
  endfunction

endpackage

// File: rtl/exec_lat_decode.sv
// Combinational decode of an issued instruction into its final latency
// count and whether it is an IN (receive-buffer read).
module exec_lat_decode
  import exec_pkg::*;
#(
  parameter int unsigned FADD_LAT  = 2,
  parameter int unsigned FSQRT_LAT = 4,
  parameter int unsigned DIV_LAT   = 8
) (
  input  logic [1:0] op_type,
  input  logic [5:0] instr,
  output logic [3:0] final_cnt,
  output logic       is_in_op
);

  always_comb begin
    final_cnt = 4'd0;
    is_in_op  = 1'b0;
    case (op_type)
      OPT_FPU: begin
        if (is_fadd_class(instr)) begin
          final_cnt = 4'(FADD_LAT);
        end else if (instr == FPU_SQRT) begin
          final_cnt = 4'(FSQRT_LAT);
        end
      end
      OPT_R: begin
        if (instr == FUNC_DIV) begin
          final_cnt = 4'(DIV_LAT);
        end
      end
      OPT_IJ: begin
        is_in_op = (instr == OP_IN);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/exec_sequencer.sv
// Execute-stage multi-cycle controller: drives the latency count, front-end
// stall, writeback enable, IN consume pulse and a saturating stall counter.
module exec_sequencer
  import exec_pkg::*;
#(
  parameter int unsigned FADD_LAT  = 2,
  parameter int unsigned FSQRT_LAT = 4,
  parameter int unsigned DIV_LAT   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        issue_valid,
  input  logic [1:0]  op_type,
  input  logic [5:0]  instr,
  input  logic        in_valid,
  input  logic        flush,
  output logic [3:0]  latancy,
  output logic        stall,
  output logic        done,
  output logic        is_in,
  output logic        busy,
  output logic [31:0] stall_cycles
);

  seq_state_t  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  f_q, f_d;
  logic [3:0]  dec_f;
  logic        dec_in;
  logic        busy_q;
  logic [31:0] stall_cycles_q;

  exec_lat_decode #(
    .FADD_LAT  (FADD_LAT),
    .FSQRT_LAT (FSQRT_LAT),
    .DIV_LAT   (DIV_LAT)
  ) u_lat_decode (
    .op_type   (op_type),
    .instr     (instr),
    .final_cnt (dec_f),
    .is_in_op  (dec_in)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    f_d     = f_q;
    stall   = 1'b0;
    done    = 1'b0;
    is_in   = 1'b0;
    case (state_q)
      IDLE: begin
        if (issue_valid) begin
          if (dec_f != 4'd0) begin
            // Final count is latched here; inputs are ignored while in MULTI.
            stall   = 1'b1;
            state_d = MULTI;
            cnt_d   = 4'd1;
            f_d     = dec_f;
          end else if (dec_in && !in_valid) begin
            stall   = 1'b1;
            state_d = WAIT_IN;
          end else begin
            done  = 1'b1;
            is_in = dec_in;
          end
        end
      end
      MULTI: begin
        if (cnt_q == f_q) begin
          done    = 1'b1;
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else begin
          stall = 1'b1;
          cnt_d = cnt_q + 4'd1;
        end
      end
      WAIT_IN: begin
        if (in_valid) begin
          done    = 1'b1;
          is_in   = 1'b1;
          state_d = IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
    // Flush or reset abandons the op: no writeback, no stall.
    if (flush || rst) begin
      stall   = 1'b0;
      done    = 1'b0;
      is_in   = 1'b0;
      state_d = IDLE;
      cnt_d   = 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= 4'd0;
      f_q            <= 4'd0;
      busy_q         <= 1'b0;
      stall_cycles_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      f_q     <= f_d;
      busy_q  <= (state_d != IDLE);
      if (stall && (stall_cycles_q != 32'hFFFF_FFFF)) begin
        stall_cycles_q <= stall_cycles_q + 32'd1;
      end
    end
  end

  assign latancy      = cnt_q;
  assign busy         = busy_q;
  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// Self-checking bench for exec_sequencer: issue-time behavioural model checked
// every cycle, plus hand-computed literal expectations for the key scenarios.
module tb_exec_sequencer;

  logic        clk;
  logic        rst;
  logic        issue_valid;
  logic [1:0]  op_type;
  logic [5:0]  instr;
  logic        in_valid;
  logic        flush;
  logic [3:0]  latancy;
  logic        stall;
  logic        done;
  logic        is_in;
  logic        busy;
  logic [31:0] stall_cycles;

  int checks = 0;
  int errors = 0;

  exec_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .issue_valid  (issue_valid),
    .op_type      (op_type),
    .instr        (instr),
    .in_valid     (in_valid),
    .flush        (flush),
    .latancy      (latancy),
    .stall        (stall),
    .done         (done),
    .is_in        (is_in),
    .busy         (busy),
    .stall_cycles (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Latency table written straight from the op list with default parameters.
  function automatic int final_of(input logic [1:0] ot, input logic [5:0] ins);
    if (ot == 2'b10 && (ins == 6'd0 || ins == 6'd1 || ins == 6'd2)) return 2;
    if (ot == 2'b10 && ins == 6'b000100) return 4;
    if (ot == 2'b01 && ins == 6'b011010) return 8;
    return 0;
  endfunction

  function automatic bit is_in_instr(input logic [1:0] ot, input logic [5:0] ins);
    return (ot == 2'b00) && (ins == 6'b111110);
  endfunction

  // Model: an in-flight multi-cycle op is remembered by its issue cycle.
  int     cyc      = 0;
  int     m_t0     = -1;
  int     m_f      = 0;
  bit     m_wait   = 1'b0;
  longint m_stalls = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, got, exp);
    end
  endtask

  always @(negedge clk) begin
    int  el;
    int  f;
    bit  e_stall, e_done, e_isin, e_busy;
    int  e_lat;
    if (rst) begin
      m_t0     = -1;
      m_wait   = 1'b0;
      m_stalls = 0;
    end else begin
      e_stall = 1'b0; e_done = 1'b0; e_isin = 1'b0; e_lat = 0;
      e_busy  = (m_t0 >= 0) || m_wait;
      el = 0;
      f  = final_of(op_type, instr);
      if (m_t0 >= 0) begin
        el      = cyc - m_t0;
        e_lat   = el;
        e_stall = (el < m_f);
        e_done  = (el == m_f);
      end else if (m_wait) begin
        e_stall = !in_valid;
        e_done  = in_valid;
        e_isin  = in_valid;
      end else if (issue_valid) begin
        if (f > 0) e_stall = 1'b1;
        else if (is_in_instr(op_type, instr) && !in_valid) e_stall = 1'b1;
        else begin
          e_done = 1'b1;
          e_isin = is_in_instr(op_type, instr);
        end
      end
      if (flush) begin
        e_stall = 1'b0; e_done = 1'b0; e_isin = 1'b0;
      end
      chk("latancy", 32'(latancy), 32'(e_lat));
      chk("stall", 32'(stall), 32'(e_stall));
      chk("done", 32'(done), 32'(e_done));
      chk("is_in", 32'(is_in), 32'(e_isin));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("stall_cycles", stall_cycles, 32'(m_stalls));
      if (e_stall && m_stalls < 64'hFFFF_FFFF) m_stalls++;
      if (flush) begin
        m_t0   = -1;
        m_wait = 1'b0;
      end else if (m_t0 >= 0) begin
        if (el == m_f) m_t0 = -1;
      end else if (m_wait) begin
        if (in_valid) m_wait = 1'b0;
      end else if (issue_valid && f > 0) begin
        m_t0 = cyc;
        m_f  = f;
      end else if (issue_valid && is_in_instr(op_type, instr) && !in_valid) begin
        m_wait = 1'b1;
      end
    end
    cyc++;
  end

  // Drive one cycle of inputs just after the edge, return after outputs settle.
  task automatic step(input logic iv, input logic [1:0] ot, input logic [5:0] ins,
                      input logic inv, input logic fl, input logic r);
    @(posedge clk);
    #1;
    issue_valid = iv;
    op_type     = ot;
    instr       = ins;
    in_valid    = inv;
    flush       = fl;
    rst         = r;
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 2'b00, 6'd0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; issue_valid = 1'b0; op_type = 2'b00; instr = 6'd0;
    in_valid = 1'b1; flush = 1'b0;
    step(1'b0, 2'b00, 6'd0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 2'b00, 6'd0, 1'b1, 1'b0, 1'b1);
    idle();
    chk("rst_outputs", {latancy, stall, done, is_in, busy}, 32'd0);
    chk("rst_stall_cycles", stall_cycles, 32'd0);

    // FPU add: latancy 0,1,2 / stall 1,1,0 / done at T+2
    step(1'b1, 2'b10, 6'b000000, 1'b1, 1'b0, 1'b0);
    chk("fadd_t0", {latancy, stall, done}, {26'd0, 4'd0, 1'b1, 1'b0});
    step(1'b1, 2'b10, 6'b000000, 1'b1, 1'b0, 1'b0);
    chk("fadd_t1", {latancy, stall, done}, {26'd0, 4'd1, 1'b1, 1'b0});
    step(1'b1, 2'b10, 6'b000000, 1'b1, 1'b0, 1'b0);
    chk("fadd_t2", {latancy, stall, done}, {26'd0, 4'd2, 1'b0, 1'b1});
    idle();
    chk("fadd_stall_cycles", stall_cycles, 32'd2);

    // Back-to-back sqrt then R-type add
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 2'b10, 6'b000100, 1'b1, 1'b0, 1'b0);
      if (i == 3) chk("sqrt_t3_stall", 32'(stall), 32'd1);
    end
    chk("sqrt_t4_done", {latancy, stall, done}, {26'd0, 4'd4, 1'b0, 1'b1});
    step(1'b1, 2'b01, 6'b100000, 1'b1, 1'b0, 1'b0);
    chk("radd_t5", {latancy, stall, done}, {26'd0, 4'd0, 1'b0, 1'b1});
    idle();

    // IN waiting three cycles on the receive buffer
    for (int i = 0; i < 3; i++) step(1'b1, 2'b00, 6'b111110, 1'b0, 1'b0, 1'b0);
    chk("in_wait_stall", {stall, done, is_in, busy}, {28'd0, 4'b1001});
    step(1'b1, 2'b00, 6'b111110, 1'b1, 1'b0, 1'b0);
    chk("in_done", {stall, done, is_in, busy}, {28'd0, 4'b0111});
    idle();
    chk("in_after", {stall, done, is_in, busy}, 32'd0);

    // IN with data already present: same-cycle consume
    step(1'b1, 2'b00, 6'b111110, 1'b1, 1'b0, 1'b0);
    chk("in_ready", {stall, done, is_in}, {29'd0, 3'b011});
    idle();
    chk("in_ready_busy", 32'(busy), 32'd0);

    // Div flushed at T+3, then a single-cycle op at T+4
    for (int i = 0; i < 3; i++) step(1'b1, 2'b01, 6'b011010, 1'b1, 1'b0, 1'b0);
    step(1'b1, 2'b01, 6'b011010, 1'b1, 1'b1, 1'b0);
    chk("div_flush", {latancy, stall, done}, {26'd0, 4'd3, 1'b0, 1'b0});
    step(1'b1, 2'b00, 6'b001000, 1'b1, 1'b0, 1'b0);
    chk("post_flush", {latancy, stall, done, busy}, {27'd0, 4'd0, 1'b0, 1'b1, 1'b0});
    idle();

    // Reset mid-div at cnt=2
    step(1'b1, 2'b01, 6'b011010, 1'b1, 1'b0, 1'b0);
    step(1'b1, 2'b01, 6'b011010, 1'b1, 1'b0, 1'b0);
    step(1'b1, 2'b01, 6'b011010, 1'b1, 1'b0, 1'b1);
    chk("pre_rst_lat", 32'(latancy), 32'd2);
    idle();
    chk("mid_rst_outputs", {latancy, stall, done, is_in, busy}, 32'd0);
    chk("mid_rst_stall_cycles", stall_cycles, 32'd0);

    // Saturation of the stall counter
    @(posedge clk);
    #1;
    force dut.stall_cycles_q = 32'hFFFF_FFFE;
    m_stalls = 64'h0000_0000_FFFF_FFFE;
    #1;
    release dut.stall_cycles_q;
    @(negedge clk);
    #1;
    chk("sat_preload", stall_cycles, 32'hFFFF_FFFE);
    for (int i = 0; i < 5; i++) step(1'b1, 2'b10, 6'b000100, 1'b1, 1'b0, 1'b0);
    idle();
    chk("sat_hold", stall_cycles, 32'hFFFF_FFFF);
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
